// File: rtl/min_max_pkg.sv
// Shared types for the min/max PWM LED bar.
package min_max_pkg;

  // Display mode, encoded exactly as it arrives on com_i.
  typedef enum logic [1:0] {
    COM_NORMAL = 2'b00,
    COM_LINEAR = 2'b01,
    COM_OFF    = 2'b10,
    COM_ON     = 2'b11
  } com_t;

  // Mode loaded into the configuration register while in reset.
  localparam com_t COM_RESET = COM_OFF;

endpackage

// File: rtl/min_max_pwm_gen.sv
// Free-running PWM counter producing the dimming enable for LEDs above the value.
module min_max_pwm_gen #(
  parameter int PWM_BITS = 3,
  parameter int DIM_DUTY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic dim_on_o
);

  // One extra bit so a duty of 2**PWM_BITS (always on) is representable.
  localparam logic [PWM_BITS:0] DUTY = (PWM_BITS + 1)'(DIM_DUTY);

  logic [PWM_BITS-1:0] pwm_cnt_reg;

  // Counter wraps naturally from all-ones back to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pwm_cnt_reg <= '0;
    else         pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
  end

  assign dim_on_o = ({1'b0, pwm_cnt_reg} < DUTY);

endmodule

// File: rtl/min_max_pwm.sv
// Clocked min/max LED bar with captured config, PWM dimming, peak-hold marker
// and a config-error flag.
module min_max_pwm
  import min_max_pkg::*;
#(
  parameter int VALSIZE  = 4,
  parameter int PWM_BITS = 3,
  parameter int DIM_DUTY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            com_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    val_i,
  input  logic                  upd_i,
  input  logic                  peak_clr_i,
  output logic [2**VALSIZE-1:0] leds_o,
  output logic                  cfg_err_o
);

  localparam int LEDS = 2**VALSIZE;

  typedef struct packed {
    com_t               com;
    logic [VALSIZE-1:0] min;
    logic [VALSIZE-1:0] max;
    logic [VALSIZE-1:0] val;
  } cfg_t;

  cfg_t               cfg_reg;
  logic [VALSIZE-1:0] peak_reg;
  logic [LEDS-1:0]    leds_reg;
  logic [LEDS-1:0]    leds_next;
  logic               cfg_err_reg;
  logic               cfg_err_next;
  logic               dim_on;
  logic               in_win;
  logic               peak_vis;
  logic [LEDS-1:0]    normal_bits;
  logic [LEDS-1:0]    linear_bits;

  min_max_pwm_gen #(
    .PWM_BITS (PWM_BITS),
    .DIM_DUTY (DIM_DUTY)
  ) u_pwm_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .dim_on_o (dim_on)
  );

  // Capture the whole configuration only on the update strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_reg.com <= COM_RESET;
      cfg_reg.min <= '0;
      cfg_reg.max <= '0;
      cfg_reg.val <= '0;
    end else if (upd_i) begin
      cfg_reg.com <= com_t'(com_i);
      cfg_reg.min <= min_i;
      cfg_reg.max <= max_i;
      cfg_reg.val <= val_i;
    end
  end

  // Peak tracks the captured value (not the raw input); clear wins over tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    peak_reg <= '0;
    else if (peak_clr_i)            peak_reg <= '0;
    else if (cfg_reg.val > peak_reg) peak_reg <= cfg_reg.val;
  end

  assign cfg_err_next = (cfg_reg.min > cfg_reg.max);
  assign in_win       = !cfg_err_next && (cfg_reg.val >= cfg_reg.min) && (cfg_reg.val <= cfg_reg.max);
  assign peak_vis     = (peak_reg > cfg_reg.val) && (peak_reg <= cfg_reg.max);

  // Per-LED decode; the index is a VALSIZE-bit constant so the top LED needs no wider compare.
  for (genvar gi = 0; gi < LEDS; gi++) begin : g_led
    localparam logic [VALSIZE-1:0] IDX = VALSIZE'(gi);
    assign normal_bits[gi] = in_win && (IDX >= cfg_reg.min) &&
                             ((IDX <= cfg_reg.val) ||
                              ((IDX <= cfg_reg.max) && (dim_on || (peak_vis && (IDX == peak_reg)))));
    assign linear_bits[gi] = (IDX <= cfg_reg.val);
  end

  // Select the LED pattern for the captured mode.
  always_comb begin
    leds_next = '0;
    case (cfg_reg.com)
      COM_NORMAL: leds_next = normal_bits;
      COM_LINEAR: leds_next = linear_bits;
      COM_OFF:    leds_next = '0;
      COM_ON:     leds_next = '1;
      default:    leds_next = '0;
    endcase
  end

  // Output stage: one cycle behind the config registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      leds_reg    <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      leds_reg    <= leds_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  assign leds_o    = leds_reg;
  assign cfg_err_o = cfg_err_reg;

endmodule
